// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode constants, FSM states and datapath mux encodings for multicycle_ctrl
package mips_ctrl_pkg;
  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ADDI  = 3'd1;
  localparam logic [2:0] OP_LB    = 3'd2;
  localparam logic [2:0] OP_SB    = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_J     = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;
  localparam logic [1:0] ASB_B    = 2'd0;
  localparam logic [1:0] ASB_ONE  = 2'd1;
  localparam logic [1:0] ASB_IMM  = 2'd2;
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    ALU_WB, MEM_WB, BRANCH, JUMP, HALT
  } state_t;
endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-style control FSM driving datapath enables, muxes and memory handshake
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            ir_en,
  output logic            ab_en,
  output logic            aluout_en,
  output logic            mdr_en,
  output logic            rf_we,
  output logic            mem_req,
  output logic            mem_we,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_src,
  output logic            rf_src,
  output logic            halted,
  output logic            illegal_op
);
  state_t state, nxt;
  logic   illegal_q, bad;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= nxt;
      illegal_q <= illegal_q | bad;
    end
  end
  // unknown or out-of-range opcodes fall to default, so X traps to HALT as well
  always_comb begin
    nxt = state;
    bad = 1'b0;
    case (state)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE:
        case (op)
          OP_W'(OP_RTYPE):             nxt = EXEC_R;
          OP_W'(OP_ADDI):              nxt = EXEC_I;
          OP_W'(OP_LB), OP_W'(OP_SB):  nxt = MEM_ADDR;
          OP_W'(OP_BEQ):               nxt = BRANCH;
          OP_W'(OP_J):                 nxt = JUMP;
          OP_W'(OP_NOP):               nxt = FETCH;
          OP_W'(OP_HALT):              nxt = HALT;
          default: begin
            nxt = HALT;
            bad = 1'b1;
          end
        endcase
      EXEC_R, EXEC_I: nxt = ALU_WB;
      MEM_ADDR: nxt = (op == OP_W'(OP_LB)) ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
      HALT:     nxt = HALT;
      default:  nxt = FETCH;
    endcase
  end
  // reset gates every output so nothing leaks out while the FSM is being forced to FETCH
  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    ab_en      = 1'b0;
    aluout_en  = 1'b0;
    mdr_en     = 1'b0;
    rf_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    alu_src_b  = ASB_B;
    pc_src     = PCS_ALU;
    rf_src     = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      halted     = state == HALT;
      illegal_op = illegal_q;
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = ASB_ONE;
          ir_en     = mem_ready;
          pc_en     = mem_ready;
        end
        DECODE: ab_en = 1'b1;
        EXEC_R: aluout_en = 1'b1;
        EXEC_I, MEM_ADDR: begin
          aluout_en = 1'b1;
          alu_src_b = ASB_IMM;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          mdr_en  = mem_ready;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        ALU_WB: rf_we = 1'b1;
        MEM_WB: begin
          rf_we  = 1'b1;
          rf_src = 1'b1;
        end
        BRANCH: begin
          pc_src = PCS_ALUOUT;
          pc_en  = zero;
        end
        JUMP: begin
          pc_src = PCS_JUMP;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: expands random instructions into per-cycle expected outputs; a monitor scores them
module tb_multicycle_ctrl;
  localparam logic [14:0] PC = 15'h4000, IR = 15'h2000, AB = 15'h1000, AO = 15'h0800;
  localparam logic [14:0] MDR = 15'h0400, WE = 15'h0200, MQ = 15'h0100, MW = 15'h0080;
  localparam logic [14:0] ASB1 = 15'h0020, ASB2 = 15'h0040, PCS1 = 15'h0008, PCS2 = 15'h0010;
  localparam logic [14:0] RFS = 15'h0004, HLT = 15'h0002, ILL = 15'h0001;
  typedef struct {
    logic        r, mr, z;
    logic [3:0]  op;
    logic [14:0] e;
    string       tag;
  } cyc_t;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] op = '0;
  logic pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we, mem_req, mem_we, rf_src, halted, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [14:0] got;
  cyc_t stim_q[$], exp_q[$];
  int tests = 0, fails = 0, ncyc = 0;
  always #5 clk = ~clk;
  multicycle_ctrl #(.OP_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .ab_en(ab_en), .aluout_en(aluout_en), .mdr_en(mdr_en),
    .rf_we(rf_we), .mem_req(mem_req), .mem_we(mem_we), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .rf_src(rf_src), .halted(halted), .illegal_op(illegal_op)
  );
  assign got = {pc_en, ir_en, ab_en, aluout_en, mdr_en, rf_we, mem_req, mem_we,
                alu_src_b, pc_src, rf_src, halted, illegal_op};
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  task automatic put(input logic r, mr, z, input logic [3:0] o, input logic [14:0] e, input string t);
    cyc_t c;
    c.r = r; c.mr = mr; c.z = z; c.op = o; c.e = e; c.tag = t;
    stim_q.push_back(c);
  endtask
  task automatic do_reset(input int n);
    repeat (n) put(1'b1, rb(), rb(), 4'($urandom), '0, "reset");
  endtask
  task automatic fetch(input logic [3:0] o, input int fw, input string t);
    repeat (fw) put(1'b0, 1'b0, rb(), o, MQ | ASB1, t);
    put(1'b0, 1'b1, rb(), o, MQ | ASB1 | IR | PC, t);
  endtask
  // one instruction, from fetch acceptance to the next fetch; mem_ready is random where it must be ignored
  task automatic instr(input logic [3:0] o, input int fw, mw, input logic z, input string t);
    fetch(o, fw, t);
    put(1'b0, rb(), rb(), o, AB, t);
    case (o)
      4'd0: begin put(1'b0, rb(), rb(), o, AO, t); put(1'b0, rb(), rb(), o, WE, t); end
      4'd1: begin put(1'b0, rb(), rb(), o, AO | ASB2, t); put(1'b0, rb(), rb(), o, WE, t); end
      4'd2: begin
        put(1'b0, rb(), rb(), o, AO | ASB2, t);
        repeat (mw) put(1'b0, 1'b0, rb(), o, MQ, t);
        put(1'b0, 1'b1, rb(), o, MQ | MDR, t);
        put(1'b0, rb(), rb(), o, WE | RFS, t);
      end
      4'd3: begin
        put(1'b0, rb(), rb(), o, AO | ASB2, t);
        repeat (mw) put(1'b0, 1'b0, rb(), o, MQ | MW, t);
        put(1'b0, 1'b1, rb(), o, MQ | MW, t);
      end
      4'd4: put(1'b0, rb(), z, o, PCS1 | (z ? PC : 15'h0), t);
      4'd5: put(1'b0, rb(), rb(), o, PC | PCS2, t);
      4'd6: ;
      default: repeat (20) put(1'b0, rb(), rb(), o, HLT | (o > 4'd7 ? ILL : 15'h0), t);
    endcase
  endtask
  initial begin
    cyc_t c;
    do_reset(2);
    instr(4'd1, 0, 0, 1'b0, "addi");
    instr(4'd2, 0, 3, 1'b0, "lb_wait3");
    instr(4'd4, 1, 0, 1'b1, "beq_z1");
    instr(4'd4, 0, 0, 1'b0, "beq_z0");
    instr(4'd3, 2, 2, 1'b0, "sb");
    for (int i = 0; i < 40; i++)
      instr(4'($urandom_range(0, 6)), $urandom_range(0, 2), $urandom_range(0, 3), rb(), "rand");
    instr(4'd7, 0, 0, 1'b0, "halt");
    do_reset(1);
    instr(4'd6, 0, 0, 1'b0, "nop_after_halt");
    repeat (2) put(1'b0, 1'b0, rb(), 4'd0, MQ | ASB1, "rst_fetch");
    do_reset(1);
    instr(4'd0, 0, 0, 1'b0, "rtype");
    fetch(4'd2, 0, "rst_memrd");
    put(1'b0, rb(), rb(), 4'd2, AB, "rst_memrd");
    put(1'b0, rb(), rb(), 4'd2, AO | ASB2, "rst_memrd");
    repeat (2) put(1'b0, 1'b0, rb(), 4'd2, MQ, "rst_memrd");
    do_reset(1);
    instr(4'd5, 0, 0, 1'b0, "jump");
    instr(4'd9, 1, 0, 1'b0, "illegal");
    do_reset(1);
    instr(4'd1, 0, 0, 1'b0, "addi_after_illegal");
    while (stim_q.size() > 0) begin
      @(negedge clk);
      c = stim_q.pop_front();
      rst = c.r; mem_ready = c.mr; zero = c.z; op = c.op;
      exp_q.push_back(c);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    cyc_t c;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        ncyc++;
        tests++;
        if (got !== c.e) begin
          fails++;
          $display("FAIL %s cycle %0d op=%0d: got %b required %b", c.tag, ncyc, c.op, got, c.e);
        end
      end
    end
  end
endmodule
